// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, loadable instruction memory and IDLE/RUN/HALT fetch control.
// Define IFU_RETIRE_COUNT_EN to build the saturating retired-instruction counter.
module instruction_fetch_unit #(
    parameter int IW = 16,
    parameter int AW = 8,
    parameter int DEPTH = 256,
    parameter logic [IW-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          start,
    input  logic          branch_taken,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] instr,
    output logic [1:0]    opcode,
    output logic [2:0]    rs,
    output logic [2:0]    rt,
    output logic [2:0]    rd,
    output logic [7:0]    imm,
    output logic          valid,
    output logic          halted,
    output logic [15:0]   retired
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, br_off;
    logic [IW-1:0] mem_q [DEPTH];
    logic          mem_we;
    assign pc     = pc_q;
    assign instr  = mem_q[pc_q];
    assign opcode = instr[15:14];
    assign rs     = instr[13:11];
    assign rt     = instr[10:8];
    assign rd     = instr[7:5];
    assign imm    = instr[7:0];
    // the size cast sign-extends for AW>8 and keeps the low AW bits for AW<8
    assign br_off = AW'($signed(imm));
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid   = 1'b0;
        halted  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                mem_we = prog_we;
                if (start) state_d = RUN;
            end
            RUN: begin
                valid = instr != HALT_WORD;
                if (!valid) state_d = HALT;
                else pc_d = branch_taken ? pc_q + AW'(1) + br_off : pc_q + AW'(1);
            end
            HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[prog_addr] <= prog_data;
    end
`ifdef IFU_RETIRE_COUNT_EN
    logic [15:0] ret_q, ret_d;
    assign ret_d = (state_q == HALT && start) ? 16'd0 :
                   (valid && ret_q != 16'hFFFF) ? ret_q + 16'd1 : ret_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ret_q <= '0;
        else ret_q <= ret_d;
    end
    assign retired = ret_q;
`else
    assign retired = '0;
`endif
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the single-cycle MIPS-like processor, directly upstream of the main control decoder. Holds the program counter and an internal, loadable instruction memory. Presents the current instruction and its split fields; the 2-bit opcode drives the main control decoder. Computes next PC (sequential or branch-taken) from datapath feedback, and runs a small IDLE/RUN/HALT controller.

Parameters:
IW, 16, instruction width in bits (fixed field layout below assumes 16)
AW, 8, PC / instruction-memory address width
DEPTH, 256, instruction-memory words (2**AW)
HALT_WORD, 16'hFFFF, instruction encoding that stops fetch

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
prog_we  input  1  instruction-memory write strobe, honoured only in IDLE
prog_addr  input  AW  instruction-memory write address
prog_data  input  IW  instruction-memory write data
start  input  1  IDLE->RUN request
branch_taken  input  1  from datapath: Branch AND ALU zero, current instruction
pc  output  AW  current program counter
instr  output  IW  imem[pc]
opcode  output  2  instr[15:14], feeds main control decoder
rs  output  3  instr[13:11]
rt  output  3  instr[10:8]
rd  output  3  instr[7:5]
imm  output  8  instr[7:0]
valid  output  1  high in RUN when instr is executable (not HALT_WORD)
halted  output  1  high in HALT
retired  output  16  retired-instruction count (optional feature)

Behaviour:
- Reset, asynchronous, active-high: state=IDLE, pc=0, retired=0, valid=0, halted=0. Memory contents are not cleared by reset.
- instr, opcode, rs, rt, rd, imm: combinational from imem[pc] in all states. Zero-latency read, as required for single-cycle execution.
- State machine:
  - IDLE: prog_we writes imem[prog_addr]=prog_data at clk edge. pc held. start=1 -> RUN, pc stays 0. prog_we and start asserted together: the write completes and the state moves to RUN on the same edge.
  - RUN: prog_we ignored. valid = (instr != HALT_WORD).
    - If instr == HALT_WORD: next state HALT, pc held, branch_taken ignored.
    - Else if branch_taken: pc <= pc + 1 + sign_extend(imm). Arithmetic is AW-bit modulo 2**AW, carries discarded. Negative offsets wrap below 0 to the top of memory.
    - Else: pc <= pc + 1. Wraps from 2**AW-1 to 0.
  - HALT: pc frozen, valid=0, halted=1. start=1 -> IDLE with pc <= 0 (re-run or reprogram). Otherwise stay in HALT.
- start is ignored in RUN.
- branch_taken is ignored outside RUN.
- Reset asserted mid-RUN: immediate return to IDLE with pc=0, without waiting for a clock edge. Programmed memory is retained.
- imm sign extension: bit 7 replicated to AW bits. When AW<8, the low AW bits of imm are used.

Optional Feature:
Macro: IFU_RETIRE_COUNT_EN
- Defined: retired is a 16-bit register, reset to 0. It increments by 1 on each RUN-state edge where valid=1, saturating at 16'hFFFF. It clears on the HALT->IDLE transition.
- Undefined: retired is tied to 0 and no counter logic is built. The port always exists.

Test Plan:
- Reset: assert reset mid-cycle -> pc=0, state IDLE, valid=0, halted=0 immediately, before the next clk edge.
- Sequential fetch: load imem[0..2]=16'h0123, 16'h4456, 16'hFFFF; pulse start -> pc 0,1,2 on successive edges; opcode 00 then 01; halted=1 one edge after pc=2; retired=2 when IFU_RETIRE_COUNT_EN is defined.
- Forward branch: imem[0]=16'h8003 with branch_taken=1 -> next pc=4. Backward branch: imem[5]=16'h80FD with branch_taken=1 -> next pc=3.
- Wrap-around: jump to pc=255 with imem[255] non-halt, branch_taken=0 -> next pc=0. Branch at pc=1 with imm=8'hF0 -> pc=242.
- Program-port lockout: prog_we in RUN with prog_addr=0, prog_data=16'hFFFF -> imem[0] unchanged, verified on a re-run after HALT->start->IDLE->start.
- Reset mid-RUN at pc=7 -> pc=0, IDLE, memory contents intact; start -> fetch resumes from pc 0 with the same program.
